// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit bank: frame geometry and the
// serializer state encoding used by every TX port.
// Ports: none (package only).
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;  // start + 8 data + stop
  localparam int UART_IDX_W      = $clog2(UART_DATA_BITS);

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;
  typedef logic [UART_IDX_W-1:0]     uart_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_port.sv
// One UART transmit port: a frame FIFO feeding an 8N1 serializer.
// Latency: a frame written at edge c can launch its start bit on the first
//   bit_cke edge at or after c+1; tx is registered and moves only on bit_cke edges.
// Backpressure: none upstream; a write to a full FIFO (with no pop on that
//   edge) is dropped and latches the sticky overflow flag.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   data, we    - frame byte and its write enable
//   bit_cke     - one-clk pulse per bit period
//   tx          - serial output, idle high
//   full, busy, overflow - FIFO full, port active, sticky frame-dropped flag
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int depth = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  uart_byte_t data,
  input  logic       we,
  input  logic       bit_cke,
  output logic       tx,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(depth);
  // depth is a power of two, so depth == 2**AW
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  uart_byte_t    mem [depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          push;
  logic          pop;

  // ---------------------------------------------------------------------------
  // Serializer registers
  // ---------------------------------------------------------------------------
  uart_tx_state_e state, state_nxt;
  uart_byte_t     shift, shift_nxt;
  uart_idx_t      idx, idx_nxt;
  logic           tx_r, tx_nxt;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign push  = we && (!full || pop);
  assign busy  = (state != IDLE) || !empty;
  assign tx    = tx_r;

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (we && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
      tx_r  <= 1'b1;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;
      idx   <= idx_nxt;
      tx_r  <= tx_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM: next state and pop. Everything holds unless bit_cke is set.
  // empty is the pre-write occupancy, so a frame written on this edge is never
  // popped on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    idx_nxt   = idx;
    tx_nxt    = tx_r;
    pop       = 1'b0;
    if (bit_cke) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            tx_nxt = 1'b1;
          end
        end
        START: begin
          // Bit 0 goes out unshifted; DATA shifts before presenting each later bit.
          tx_nxt    = shift[0];
          idx_nxt   = '0;
          state_nxt = DATA;
        end
        DATA: begin
          if (idx != uart_idx_t'(UART_DATA_BITS - 1)) begin
            shift_nxt = shift >> 1;
            tx_nxt    = shift[1];
            idx_nxt   = idx + uart_idx_t'(1);
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end
        end
        STOP: begin
          // Chaining straight into the next start bit keeps streams gap-free.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          tx_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_bank.sv
// Bank of n independent UART transmit ports fed from the matrix frame bus.
// Latency: per port as uart_tx_port (frame in FIFO after the write edge,
//   start bit on the next bit_cke edge at the earliest).
// Backpressure: none; each port drops frames when full and flags overflow.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   data, cke  - shared frame byte, per-port write enables (any number set)
//   bit_cke    - shared one-clk bit-rate pulse
//   tx, full, busy, overflow - per-port serial output and status
module uart_tx_bank
  import uart_pkg::*;
#(
  parameter int n     = 8,
  parameter int depth = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  uart_byte_t   data,
  input  logic [n-1:0] cke,
  input  logic         bit_cke,
  output logic [n-1:0] tx,
  output logic [n-1:0] full,
  output logic [n-1:0] busy,
  output logic [n-1:0] overflow
);

  for (genvar i = 0; i < n; i++) begin : g_port
    uart_tx_port #(
      .depth(depth)
    ) u_port (
      .clk     (clk),
      .reset   (reset),
      .data    (data),
      .we      (cke[i]),
      .bit_cke (bit_cke),
      .tx      (tx[i]),
      .full    (full[i]),
      .busy    (busy[i]),
      .overflow(overflow[i])
    );
  end

endmodule

// File: tb/tb_uart_tx_bank.sv
// Testbench for uart_tx_bank: directed scenarios plus randomized traffic,
// compared every cycle against a frame-level queue model.
// Ports: none (top-level bench).
module tb_uart_tx_bank;
  import uart_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   data;
  logic [N-1:0] cke;
  logic         bit_cke;
  logic [N-1:0] tx;
  logic [N-1:0] full;
  logic [N-1:0] busy;
  logic [N-1:0] overflow;

  always #5 clk = ~clk;

  uart_tx_bank #(
    .n    (N),
    .depth(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data    (data),
    .cke     (cke),
    .bit_cke (bit_cke),
    .tx      (tx),
    .full    (full),
    .busy    (busy),
    .overflow(overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each port is a queue of pending bytes plus the 10-bit
  // wire image of the frame being sent and the position within it (-1 idle).
  // A new frame may start when idle or when the stop bit has been shown.
  // ---------------------------------------------------------------------------
  logic [7:0] mq   [N][$];
  int         pos  [N];
  logic [9:0] frm  [N];
  logic       movf [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      pos[i]  = -1;
      frm[i]  = '1;
      movf[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [7:0] d, input logic [N-1:0] ck, input logic bc);
    for (int i = 0; i < N; i++) begin
      logic       boundary;
      logic [7:0] b;
      boundary = (pos[i] < 0) || (pos[i] == UART_FRAME_BITS - 1);
      if (bc) begin
        if (boundary && mq[i].size() > 0) begin
          b      = mq[i].pop_front();
          frm[i] = {1'b1, b, 1'b0};
          pos[i] = 0;
        end else if (boundary) begin
          pos[i] = -1;
        end else begin
          pos[i] = pos[i] + 1;
        end
      end
      if (ck[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(d);
        else movf[i] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] e_tx, e_full, e_busy, e_ovf;
    for (int i = 0; i < N; i++) begin
      e_tx[i]   = (pos[i] < 0) ? 1'b1 : frm[i][pos[i]];
      e_full[i] = (mq[i].size() == DEPTH);
      e_busy[i] = (pos[i] >= 0) || (mq[i].size() > 0);
      e_ovf[i]  = movf[i];
    end
    check("tx", tx, e_tx);
    check("full", full, e_full);
    check("busy", busy, e_busy);
    check("ovf", overflow, e_ovf);
  endtask

  // tx vectors seen after each bit_cke edge
  logic [N-1:0] cap [$];
  // expected serial bit stream for one port
  logic         eb  [$];

  task automatic tick();
    logic bc;
    bc = bit_cke;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(data, cke, bc);
    @(negedge clk);
    compare_all();
    if (bc && !reset) cap.push_back(tx);
  endtask

  task automatic cyc(input logic [7:0] d, input logic [N-1:0] ck, input logic bc);
    data    = d;
    cke     = ck;
    bit_cke = bc;
    tick();
  endtask

  task automatic add_frame(input logic [7:0] b);
    eb.push_back(1'b0);
    for (int k = 0; k < 8; k++) eb.push_back(b[k]);
    eb.push_back(1'b1);
  endtask

  task automatic check_cap(input string tag, input int port);
    int lim;
    check({tag, "_len"}, cap.size(), eb.size());
    lim = (cap.size() < eb.size()) ? cap.size() : eb.size();
    for (int k = 0; k < lim; k++) check(tag, cap[k][port], eb[k]);
  endtask

  initial begin
    reset   = 1'b0;
    data    = '0;
    cke     = '0;
    bit_cke = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_tx", tx, 8'hFF);
    check("rst_full", full, 8'h00);
    check("rst_busy", busy, 8'h00);
    check("rst_ovf", overflow, 8'h00);
    repeat (3) tick();
    reset = 1'b0;

    // Single frame 0xA5 on port 0, bit_cke every 4 clk
    cap.delete();
    cyc(8'hA5, 8'h01, 1'b0);
    for (int k = 0; k < 48; k++) cyc(8'($urandom), '0, (k % 4) == 3);
    eb.delete();
    add_frame(8'hA5);
    eb.push_back(1'b1);
    eb.push_back(1'b1);
    check_cap("single", 0);
    for (int k = 0; k < cap.size(); k++) check("single_others", cap[k] | 8'h01, 8'hFF);
    check("single_busy", busy[0], 1'b0);

    // Broadcast 0x3C to ports 0, 2, 7
    cap.delete();
    cyc(8'h3C, 8'h85, 1'b0);
    for (int k = 0; k < 24; k++) cyc(8'($urandom), '0, (k % 2) == 1);
    eb.delete();
    add_frame(8'h3C);
    eb.push_back(1'b1);
    eb.push_back(1'b1);
    check("bcast_len", cap.size(), eb.size());
    for (int k = 0; k < cap.size() && k < eb.size(); k++)
      check("bcast", cap[k], eb[k] ? 8'hFF : 8'h7A);

    // Back-to-back 0x00, 0xFF, 0x55 on port 1 with bit_cke continuous
    cap.delete();
    cyc(8'h00, 8'h02, 1'b1);
    cyc(8'hFF, 8'h02, 1'b1);
    cyc(8'h55, 8'h02, 1'b1);
    for (int k = 0; k < 29; k++) cyc(8'($urandom), '0, 1'b1);
    eb.delete();
    eb.push_back(1'b1);
    add_frame(8'h00);
    add_frame(8'hFF);
    add_frame(8'h55);
    eb.push_back(1'b1);
    check_cap("b2b", 1);

    // Overflow on port 3: 18 writes with bit_cke off
    for (int i = 0; i < DEPTH + 2; i++) begin
      cyc(8'(i), 8'h08, 1'b0);
      if (i == DEPTH - 1) begin
        check("ovf_full16", full[3], 1'b1);
        check("ovf_clear16", overflow[3], 1'b0);
      end
      if (i == DEPTH) check("ovf_set17", overflow[3], 1'b1);
    end
    cap.delete();
    for (int k = 0; k < 165; k++) cyc(8'($urandom), '0, 1'b1);
    eb.delete();
    for (int i = 0; i < DEPTH; i++) add_frame(8'(i));
    repeat (5) eb.push_back(1'b1);
    check_cap("ovf_stream", 3);
    check("ovf_sticky", overflow[3], 1'b1);

    // Full FIFO on port 4 with a write on the same edge as an IDLE pop
    for (int i = 0; i < DEPTH; i++) cyc(8'h40 + 8'(i), 8'h10, 1'b0);
    check("fp_full", full[4], 1'b1);
    cap.delete();
    cyc(8'h99, 8'h10, 1'b1);
    check("fp_ovf", overflow[4], 1'b0);
    check("fp_still_full", full[4], 1'b1);
    for (int k = 0; k < 170; k++) cyc(8'($urandom), '0, 1'b1);
    eb.delete();
    for (int i = 0; i < DEPTH; i++) add_frame(8'h40 + 8'(i));
    add_frame(8'h99);
    eb.push_back(1'b1);
    check_cap("fp_stream", 4);

    // Reset during data bit 4 of 0xF0 on port 5
    cyc(8'hF0, 8'h20, 1'b1);
    for (int k = 0; k < 6; k++) cyc(8'($urandom), '0, 1'b1);
    check("mid_busy", busy[5], 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_tx", tx, 8'hFF);
    check("mid_rst_busy", busy, 8'h00);
    check("mid_rst_full", full, 8'h00);
    check("mid_rst_ovf", overflow, 8'h00);
    cke     = '0;
    bit_cke = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    cap.delete();
    for (int k = 0; k < 20; k++) cyc(8'($urandom), '0, 1'b1);
    check("post_rst_len", cap.size(), 20);
    for (int k = 0; k < cap.size(); k++) check("post_rst_idle", cap[k], 8'hFF);

    // Randomized traffic with varying bit rates
    for (int blk = 0; blk < 6; blk++) begin
      for (int k = 0; k < 500; k++) begin
        logic [N-1:0] ck;
        logic         bc;
        ck = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        case (blk % 3)
          0:       bc = 1'b1;
          1:       bc = ($urandom_range(0, 1) == 0);
          default: bc = ($urandom_range(0, 7) == 0);
        endcase
        cyc(8'($urandom), ck, bc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
